mem_arbiter: RTL and testbench

Fixed-priority arbiter with starvation guard that shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined CPU. It sits between the fetch/memory stages and RAM, and produces the `ihit`/`dhit` strobes that the hazard unit consumes for stall and enable decisions. It retries on RAM error and abandons a grant whose requester withdraws, such as a fetch flushed by a taken branch.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data memory.
// Data has fixed priority, except when a fetch has waited through STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [7:0]  err_count
);

  localparam int SW_RAW = $clog2(STARVE_MAX + 1);
  localparam int SW     = (SW_RAW > 3) ? SW_RAW : 3;

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [7:0]    err_q, err_d;

  logic dreq;
  logic starve;
  logic ram_ok;
  logic ram_err;

  assign dreq    = dREN | dWEN;
  assign starve  = iREN && (dstreak_q >= STARVE_LIM);
  assign ram_ok  = (ramstate == RAM_ACCESS);
  assign ram_err = (ramstate == RAM_ERROR);

  assign iload     = ramload;
  assign dload     = ramload;
  assign err_count = err_q;

  always_comb begin
    state_d  = state_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (dreq && !starve) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ok) begin
          ihit    = 1'b1;
          state_d = IDLE;
        end
      end

      DGNT: begin
        // A simultaneous read and write is resolved as a write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ram_ok) begin
          dhit    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (state_q != IDLE && ram_err) begin
      if ((state_q == IGNT && iREN) ||
          (state_q == DGNT && dreq)) begin
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    dstreak_d = dstreak_q;
    if (ihit) begin
      dstreak_d = '0;
    end else if (dhit) begin
      if (!iREN) begin
        dstreak_d = '0;
      end else if (dstreak_q != {SW{1'b1}}) begin
        dstreak_d = dstreak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      err_q     <= err_d;
    end
  end

  logic unused_ok;
  assign unused_ok = (ramstate == RAM_FREE) | (ramstate == RAM_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; hits are matched against a queue
// of expected (requester, cycle, address, data) entries.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [7:0]  err_count;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          d;
    int          c;
    logic [31:0] a;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0] wseq [4] = '{BUSY, ERR, BUSY, ACC};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_hit(bit d, int c, logic [31:0] a, logic [31:0] v);
    exp_t x;
    x.d = d;
    x.c = c;
    x.a = a;
    x.v = v;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (ihit === 1'b1 || dhit === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_hit", {30'd0, ihit, dhit}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("hit_kind", {30'd0, ihit, dhit}, e.d ? 32'd1 : 32'd2);
        chk("hit_cyc", cyc, e.c);
        chk("hit_addr", ramaddr, e.a);
        chk("hit_data", e.d ? dload : iload, e.v);
      end
    end
  end

  int t;

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramstate = ACC; ramload = 32'h2408000A;
    step(); step();

    // reset with a fetch pending
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h0;
    t = cyc;
    exp_hit(1'b0, t + 2, 32'h0, 32'h2408000A);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_dhit", {31'd0, dhit}, 32'd0);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    step();
    step(); iREN = 1'b0;
    step();

    // simultaneous requests: data first
    t = cyc;
    iREN = 1'b1; iaddr = 32'h80;
    dREN = 1'b1; daddr = 32'h100;
    ramload = 32'h11112222;
    exp_hit(1'b1, t + 1, 32'h100, 32'h11112222);
    exp_hit(1'b0, t + 3, 32'h80, 32'h11112222);
    step();
    step(); dREN = 1'b0;
    step();
    step(); iREN = 1'b0;
    step();

    // starvation guard
    t = cyc;
    iREN = 1'b1; iaddr = 32'h84;
    dREN = 1'b1; daddr = 32'h300;
    ramload = 32'h33334444;
    for (int k = 0; k < 4; k++)
      exp_hit(1'b1, t + 1 + 2 * k, 32'h300, 32'h33334444);
    exp_hit(1'b0, t + 9, 32'h84, 32'h33334444);
    exp_hit(1'b1, t + 11, 32'h300, 32'h33334444);
    repeat (12) step();
    iREN = 1'b0; dREN = 1'b0;
    step();

    // wait states and one error
    t = cyc;
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    ramload = 32'h55556666;
    exp_hit(1'b1, t + 4, 32'h200, 32'h55556666);
    for (int k = 0; k < 4; k++) begin
      step();
      ramstate = wseq[k];
      @(negedge CLK);
      chk("ws_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("ws_ramREN", {31'd0, ramREN}, 32'd0);
      chk("ws_ramstore", ramstore, 32'hDEADBEEF);
    end
    step();
    dWEN = 1'b0; ramstate = ACC;
    @(negedge CLK);
    chk("ws_err", {24'd0, err_count}, 32'd1);
    chk("ws_ramWEN_off", {31'd0, ramWEN}, 32'd0);

    // fetch withdrawn mid-grant
    step();
    iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("wd_ramREN_on", {31'd0, ramREN}, 32'd1);
    chk("wd_ramaddr", ramaddr, 32'h44);
    step();
    iREN = 1'b0;
    @(negedge CLK);
    chk("wd_ramREN_drop", {31'd0, ramREN}, 32'd0);
    chk("wd_ihit", {31'd0, ihit}, 32'd0);
    step();
    iREN = 1'b1; iaddr = 32'h40; ramstate = ACC;
    ramload = 32'h77778888;
    exp_hit(1'b0, cyc + 1, 32'h40, 32'h77778888);
    @(negedge CLK);
    chk("wd_idle_ramREN", {31'd0, ramREN}, 32'd0);
    step();
    step(); iREN = 1'b0;

    // read and write together resolve as a write
    step();
    t = cyc;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h208;
    dstore = 32'h12345678; ramstate = BUSY;
    ramload = 32'h9999AAAA;
    exp_hit(1'b1, t + 2, 32'h208, 32'h9999AAAA);
    step();
    @(negedge CLK);
    chk("rw_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("rw_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rw_ramstore", ramstore, 32'h12345678);
    step();
    ramstate = ACC;
    @(negedge CLK);
    chk("rw_ramWEN_acc", {31'd0, ramWEN}, 32'd1);
    step();
    dREN = 1'b0; dWEN = 1'b0;

    // reset during a data grant
    step();
    dREN = 1'b1; daddr = 32'h210; ramstate = BUSY;
    step();
    RST = 1'b1;
    @(negedge CLK);
    chk("mr_ramREN_on", {31'd0, ramREN}, 32'd1);
    step();
    RST = 1'b0; ramstate = ACC;
    exp_hit(1'b1, cyc + 1, 32'h210, 32'h9999AAAA);
    @(negedge CLK);
    chk("mr_ramREN_off", {31'd0, ramREN}, 32'd0);
    chk("mr_dhit", {31'd0, dhit}, 32'd0);
    chk("mr_err", {24'd0, err_count}, 32'd0);
    step();
    step(); dREN = 1'b0;

    // error counter saturates
    step();
    dREN = 1'b1; daddr = 32'h220; ramstate = ERR;
    repeat (260) step();
    ramstate = ACC;
    exp_hit(1'b1, cyc, 32'h220, 32'h9999AAAA);
    @(negedge CLK);
    chk("sat_err", {24'd0, err_count}, 32'd255);
    step();
    dREN = 1'b0;

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
